apb_master_bridge: RTL

APB master that converts a simple valid/ready request stream (address, write flag, write data) into APB SETUP/ACCESS transfers and returns a one-cycle response pulse carrying read data or a timeout flag. Sits directly upstream of the team's APB memory slave and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA. Supports back-to-back transfers, slave wait states, and a configurable read-data capture delay for slaves that register PRDATA on the completing edge.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_master_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
//==============================================================================
// Package  : apb_pkg
// Brief    : Shared state encoding, default widths and timer sizing helper.
// Revision : 1.0 - initial release
//==============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // A zero timeout still needs a one-bit counter to keep the vector legal.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
//==============================================================================
// Module   : apb_wait_timer
// Brief    : Clear/enable wait-state counter with terminal-count flag.
// Revision : 1.0 - initial release
//==============================================================================
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = timer_width(TIMEOUT);
    localparam logic [CNT_W-1:0] c_tc_val = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    // tc flags the cycle whose stalled edge would be the TIMEOUT-th one.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !tc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tc = (TIMEOUT > 0) && (r_count == c_tc_val);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
//==============================================================================
// Module   : apb_master_bridge
// Brief    : Valid/ready request stream to APB master with response pulse.
// Revision : 1.0 - initial release
//==============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RDATA_DELAY = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_e        r_state;
    apb_state_e        w_next;
    logic              w_accept;
    logic              w_complete;
    logic              w_abort;
    logic              w_tc;
    logic              w_capture;
    logic              w_cap_read;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_timeout;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = !PRESET;
                if (req_valid) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL   = 1'b1;
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    w_complete = 1'b1;
                    req_ready  = !PRESET;
                    w_next     = req_valid ? ST_SETUP : ST_IDLE;
                end else if (w_tc) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = req_valid && req_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (r_state == ST_SETUP),
        .enable ((r_state == ST_ACCESS) && !PREADY),
        .tc     (w_tc)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
        end
    end

    generate
        if (RDATA_DELAY == 0) begin : g_rdata_direct
            assign w_capture  = w_complete;
            assign w_cap_read = !r_pwrite;
        end else begin : g_rdata_delay
            // Registered-read slaves present PRDATA one edge after completion.
            logic r_pend;
            logic r_pend_rd;
            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    r_pend    <= 1'b0;
                    r_pend_rd <= 1'b0;
                end else begin
                    r_pend    <= w_complete;
                    r_pend_rd <= w_complete && !r_pwrite;
                end
            end
            assign w_capture  = r_pend;
            assign w_cap_read = r_pend_rd;
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            if (w_abort) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end else if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_cap_read ? PRDATA : '0;
            end
        end
    end

    assign PADDR       = r_paddr;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire
